// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  // Instruction word paired with the address it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode handshake.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output instr_valid, instr_out, pc_out, pc_plus4,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  instr_valid, instr_out, pc_out, pc_plus4,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one imem request at a time and holds the
// returned word for decode; redirects flush the buffer and poison in-flight fetches.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  instr_fetch_if.master    bus,
  output logic             fetch_misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            discard_q, discard_d;
  logic            valid_q, valid_d;
  fetch_pkt_t      pkt_q, pkt_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            misalign_q, misalign_d;
  logic            advance;
  logic            accept_c;
  logic            transfer_c;

  // Redirect always wins; otherwise step by one word only when decode took the instruction
  function automatic logic [XLEN-1:0] sel_next_pc(input logic            redir,
                                                  input logic [XLEN-1:0] target,
                                                  input logic            adv,
                                                  input logic [XLEN-1:0] cur);
    logic [XLEN-1:0] nxt;
    nxt = cur;
    if (redir) begin
      nxt = {target[XLEN-1:2], 2'b00};
    end else if (adv) begin
      nxt = cur + XLEN'(4);
    end
    return nxt;
  endfunction

  assign accept_c   = (state_q == S_REQ) && req_q && bus.imem_ready;
  assign transfer_c = valid_q && bus.instr_ready;

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    valid_d    = valid_q;
    pkt_d      = pkt_q;
    pcp4_d     = pcp4_q;
    advance    = 1'b0;
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

    case (state_q)
      S_REQ: begin
        if (accept_c) begin
          state_d   = S_WAIT;
          discard_d = redirect_valid;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          discard_d = 1'b0;
          // A redirect in the same cycle makes this response stale as well
          if (discard_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            pkt_d   = '{pc: pc_q, instr: bus.imem_rdata};
            pcp4_d  = pc_q + XLEN'(4);
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || transfer_c) begin
          state_d = S_REQ;
          valid_d = 1'b0;
          advance = !redirect_valid;
        end
      end
      default: begin
        state_d   = S_REQ;
        discard_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase

    pc_d   = sel_next_pc(redirect_valid, redirect_pc, advance, pc_q);
    req_d  = (state_d == S_REQ);
    addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      discard_q  <= 1'b0;
      valid_q    <= 1'b0;
      pkt_q      <= '{pc: RESET_PC, instr: NOP_INSTR};
      pcp4_q     <= RESET_PC + XLEN'(4);
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
      pkt_q      <= pkt_d;
      pcp4_q     <= pcp4_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = pkt_q.instr;
  assign bus.pc_out      = pkt_q.pc;
  assign bus.pc_plus4    = pcp4_q;
  assign fetch_misalign  = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random memory/decode/redirect traffic against a transaction-level model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  instr_fetch_if bus();

  instr_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: program-order fetch pc, outstanding request, one-entry decode buffer
  logic [31:0] m_fpc, m_ipc, m_instr;
  logic        m_busy, m_stale, m_hold, m_req, m_mis;

  // Memory responder state and knobs
  logic        r_busy = 1'b0;
  int          r_cnt = 0;
  logic [31:0] r_addr = 32'h0;
  int          k_ready_pct, k_lat_min, k_lat_max, k_stray_pct;
  logic [31:0] acc_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fpc = RST_PC; m_busy = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
    m_req = 1'b0;   m_mis = 1'b0;  m_ipc = RST_PC;  m_instr = NOP;
  endtask

  task automatic model_edge(input logic redir, input logic [31:0] tgt, input logic rdy,
                            input logic rv, input logic [31:0] rd, input logic irdy);
    logic accepted, consumed, loaded;
    logic [31:0] npc;
    accepted = m_req && rdy;
    consumed = m_hold && irdy;
    npc      = m_fpc;
    loaded   = 1'b0;
    if (m_busy && rv) begin
      m_busy = 1'b0;
      if (!m_stale && !redir) begin
        loaded  = 1'b1;
        m_ipc   = m_fpc;
        m_instr = rd;
      end
      m_stale = 1'b0;
    end else if (m_busy && redir) begin
      m_stale = 1'b1;
    end
    if (m_hold && (consumed || redir)) begin
      m_hold = 1'b0;
      if (!redir) npc = m_fpc + 32'd4;
    end
    if (loaded) m_hold = 1'b1;
    if (accepted) begin
      m_busy  = 1'b1;
      m_stale = redir;
    end
    if (redir) npc = {tgt[31:2], 2'b00};
    m_fpc = npc;
    m_req = !m_busy && !m_hold;
    m_mis = redir && (tgt[1:0] != 2'b00);
  endtask

  task automatic compare();
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_hold));
    chk("imem_req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", bus.imem_addr, m_fpc);
    chk("instr_out", bus.instr_out, m_instr);
    chk("pc_out", bus.pc_out, m_ipc);
    chk("pc_plus4", bus.pc_plus4, m_ipc + 32'd4);
    chk("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
    if (m_hold) chk("instr_matches_mem", bus.instr_out, memf(m_ipc));
  endtask

  task automatic step(input logic redir, input logic [31:0] tgt, input logic irdy);
    logic rdy, rv, resp, p_req;
    logic [31:0] rd, p_addr;
    rdy  = ($urandom_range(99) < k_ready_pct);
    resp = r_busy && (r_cnt == 0);
    rd   = $urandom;
    rv   = 1'b0;
    if (resp) begin
      rv = 1'b1;
      rd = memf(r_addr);
    end else if (!r_busy && ($urandom_range(99) < k_stray_pct)) begin
      rv = 1'b1;
    end
    redirect_valid  = redir;
    redirect_pc     = tgt;
    bus.imem_ready  = rdy;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.instr_ready = irdy;
    p_req  = bus.imem_req;
    p_addr = bus.imem_addr;
    @(posedge clk);
    cyc++;
    if (resp) r_busy = 1'b0;
    else if (r_busy) r_cnt--;
    if (p_req && rdy) begin
      acc_q.push_back(p_addr);
      r_busy = 1'b1;
      r_addr = p_addr;
      r_cnt  = $urandom_range(k_lat_max, k_lat_min);
    end
    if (rst_n) model_edge(redir, tgt, rdy, rv, rd, irdy);
    #1;
    compare();
  endtask

  task automatic run_until_valid(input int maxc);
    int n = 0;
    while (!bus.instr_valid && n < maxc) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk("wait_valid", 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic run_until_accept(input int maxc);
    int n = 0;
    while (!r_busy && n < maxc) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("wait_accept", 32'(r_busy), 32'd1);
  endtask

  task automatic chk_reset_values();
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RST_PC);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr_out", bus.instr_out, NOP);
    chk("rst_pc_out", bus.pc_out, RST_PC);
    chk("rst_fetch_misalign", 32'(fetch_misalign), 32'd0);
  endtask

  initial begin
    int vc[$];
    logic [31:0] tgt;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    k_ready_pct = 100; k_lat_min = 0; k_lat_max = 0; k_stray_pct = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values();
    chk("rst_pc_plus4", bus.pc_plus4, 32'h4);
    rst_n = 1'b1;

    // Streaming: addresses 0,4,8 and one instruction every third cycle
    acc_q.delete();
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (bus.instr_valid) vc.push_back(c);
    end
    chk("stream_addr0", acc_q[0], 32'h0);
    chk("stream_addr1", acc_q[1], 32'h4);
    chk("stream_addr2", acc_q[2], 32'h8);
    chk("first_valid_cycle", 32'(vc[0]), 32'd3);
    chk("valid_period", 32'(vc[1] - vc[0]), 32'd3);
    chk("valid_count", 32'(vc.size()), 32'd3);

    // Decode stall holds the instruction and blocks fetching
    run_until_valid(20);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 32'h0, 1'b0);
      chk("stall_pc", bus.pc_out, 32'hC);
      chk("stall_instr", bus.instr_out, memf(32'hC));
      chk("stall_req", 32'(bus.imem_req), 32'd0);
    end
    step(1'b0, 32'h0, 1'b1);

    // Redirect while waiting on memory
    k_lat_min = 2; k_lat_max = 3;
    run_until_accept(10);
    acc_q.delete();
    step(1'b1, 32'h100, 1'b1);
    run_until_valid(30);
    chk("redir_wait_addr", acc_q[0], 32'h100);
    chk("redir_wait_pc", bus.pc_out, 32'h100);
    step(1'b0, 32'h0, 1'b1);
    k_lat_min = 0; k_lat_max = 0;

    // Misaligned redirect, taken in the same cycle a request is accepted
    step(1'b1, 32'h202, 1'b1);
    chk("misalign_pulse", 32'(fetch_misalign), 32'd1);
    acc_q.delete();
    step(1'b0, 32'h0, 1'b0);
    chk("misalign_clear", 32'(fetch_misalign), 32'd0);
    run_until_valid(20);
    chk("misalign_addr", acc_q[0], 32'h200);
    chk("misalign_pc", bus.pc_out, 32'h200);

    // Redirect in the hold state together with a consume
    step(1'b1, 32'h300, 1'b1);
    chk("hold_flush_valid", 32'(bus.instr_valid), 32'd0);
    acc_q.delete();
    run_until_valid(20);
    chk("hold_redir_addr", acc_q[0], 32'h300);
    chk("hold_redir_pc", bus.pc_out, 32'h300);

    // PC wrap at the top of the address space
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    run_until_valid(20);
    chk("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", bus.pc_plus4, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    run_until_valid(20);
    chk("wrap_next_pc", bus.pc_out, 32'h0);
    step(1'b0, 32'h0, 1'b1);

    // Reset during a memory wait; response lands right after release
    k_lat_min = 3; k_lat_max = 3;
    run_until_accept(10);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_values();
    step(1'b0, 32'h0, 1'b0);
    chk_reset_values();
    r_cnt = 0;
    rst_n = 1'b1;
    acc_q.delete();
    k_lat_min = 0; k_lat_max = 0;
    step(1'b0, 32'h0, 1'b0);
    chk("post_rst_valid", 32'(bus.instr_valid), 32'd0);
    run_until_valid(20);
    chk("post_rst_addr", acc_q[0], RST_PC);
    chk("post_rst_pc", bus.pc_out, RST_PC);

    // Random traffic
    k_ready_pct = 70; k_lat_min = 0; k_lat_max = 3; k_stray_pct = 10;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(11) == 0) begin
        case ($urandom_range(2))
          0:       tgt = $urandom;
          1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
          default: tgt = 32'($urandom_range(1023));
        endcase
        step(1'b1, tgt, 1'($urandom_range(99) < 60));
      end else begin
        step(1'b0, 32'h0, 1'($urandom_range(99) < 60));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
